// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one FullAdder evaluation per clock, carry held in a
// register between bits, result published only when the whole word is done.

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic CARRY
);
  assign SUM   = A ^ B ^ CIN;
  assign CARRY = (A & B) | (CIN & (A ^ B));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH:0]     w_acc_cat;
  logic               w_last;

  FullAdder u_fa (
    .A     (r_a_sr[0]),
    .B     (r_b_sr[0]),
    .CIN   (r_carry),
    .SUM   (w_fa_sum),
    .CARRY (w_fa_carry)
  );

  // Taking the upper WIDTH bits of {sum_bit, acc} is a right shift that also
  // works for WIDTH=1.
  assign w_acc_cat = {w_fa_sum, r_acc};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (START) w_state_next = S_SHIFT;
      S_SHIFT:  if (w_last) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_carry <= CIN;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_acc   <= w_acc_cat[WIDTH:1];
          r_carry <= w_fa_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_FINISH: begin
          r_sum  <= r_acc;
          r_cout <= r_carry;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (r_state != S_IDLE);
  assign DONE = (r_state == S_FINISH);
  assign SUM  = r_sum;
  assign COUT = r_cout;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH 1, 8 and 32 against
// a plain integer-addition model.

module tb_bit_serial_adder;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        CIN = 1'b0;
  logic [2:0]  start_v = '0;

  logic        busy1, done1, sum1, cout1;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy32, done32, cout32;
  logic [31:0] sum32;

  int checks = 0;
  int failures = 0;
  int sel = 1;
  int widths [3] = '{1, 8, 32};
  longint prev_res [3] = '{0, 0, 0};

  logic   obs_busy, obs_done;
  longint obs_res;

  always #5 CLK = ~CLK;

  bit_serial_adder #(.WIDTH(1)) u_w1 (
    .CLK(CLK), .RST(RST), .START(start_v[0]), .A(A[0]), .B(B[0]), .CIN(CIN),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .COUT(cout1));
  bit_serial_adder #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST(RST), .START(start_v[1]), .A(A[7:0]), .B(B[7:0]), .CIN(CIN),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8));
  bit_serial_adder #(.WIDTH(32)) u_w32 (
    .CLK(CLK), .RST(RST), .START(start_v[2]), .A(A), .B(B), .CIN(CIN),
    .BUSY(busy32), .DONE(done32), .SUM(sum32), .COUT(cout32));

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_res  = (longint'(cout8) << 8) | longint'(sum8);
    case (sel)
      0: begin
        obs_busy = busy1;
        obs_done = done1;
        obs_res  = (longint'(cout1) << 1) | longint'(sum1);
      end
      2: begin
        obs_busy = busy32;
        obs_done = done32;
        obs_res  = (longint'(cout32) << 32) | longint'(sum32);
      end
      default: ;
    endcase
  end

  function automatic longint ref_add(int w, longint a, longint b, logic c);
    longint mask;
    mask = (64'sd1 << w) - 1;
    return ((a & mask) + (b & mask) + longint'(c)) & ((64'sd1 << (w + 1)) - 1);
  endfunction

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Issue one addition on instance s, optionally poking START with new data
  // mid-flight, and verify latency, handshake and result.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input int gap, input bit poke, input string tag);
    int w;
    int done_at;
    bit busy_ok;
    bit stable;
    longint exp_res;
    w = widths[s];
    sel = s;
    repeat (gap) @(negedge CLK);
    A = a; B = b; CIN = c;
    start_v[s] = 1'b1;
    exp_res = ref_add(w, longint'(a), longint'(b), c);
    @(negedge CLK);
    start_v[s] = 1'b0;
    A = $urandom; B = $urandom; CIN = 1'($urandom);
    done_at = 0; busy_ok = 1; stable = 1;
    for (int cyc = 1; cyc <= w + 4 && done_at == 0; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (obs_busy !== 1'b1) busy_ok = 0;
      if (obs_done === 1'b1) done_at = cyc;
      else if (obs_res !== prev_res[s]) stable = 0;
      if (poke && cyc == 3) begin
        start_v[s] = 1'b1;
        A = 32'hAA;
        B = $urandom;
      end
      if (poke && cyc == 4) start_v[s] = 1'b0;
    end
    check({tag, "_done_latency"}, longint'(done_at), longint'(w + 1));
    check({tag, "_busy_held"}, longint'(busy_ok), 64'd1);
    check({tag, "_sum_stable"}, longint'(stable), 64'd1);
    @(negedge CLK);
    check({tag, "_done_pulse_end"}, longint'(obs_done), 64'd0);
    check({tag, "_busy_end"}, longint'(obs_busy), 64'd0);
    check({tag, "_result"}, obs_res, exp_res);
    prev_res[s] = exp_res;
    $display("op %s w=%0d a=0x%0h b=0x%0h cin=%0d -> {cout,sum}=0x%0h", tag, w,
             a, b, c, obs_res);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check("reset_busy", longint'(obs_busy), 64'd0);
      check("reset_done", longint'(obs_done), 64'd0);
      check("reset_result", obs_res, 64'd0);
    end

    run_op(1, 32'h5A, 32'h3C, 1'b0, 1, 1'b0, "w8_5a_3c");
    run_op(1, 32'hFF, 32'h01, 1'b0, 1, 1'b0, "w8_ff_01");
    run_op(1, 32'hFF, 32'hFF, 1'b1, 0, 1'b0, "w8_ff_ff_c1_b2b");
    run_op(1, 32'h10, 32'h20, 1'b0, 2, 1'b1, "w8_start_ignored");
    repeat (2) begin
      @(negedge CLK);
      check("w8_no_extra_done", longint'(obs_done), 64'd0);
    end

    // Abort an addition with reset in the middle of its SHIFT phase.
    sel = 1;
    A = 32'h77; B = 32'h11; CIN = 1'b0;
    start_v[1] = 1'b1;
    @(negedge CLK);
    start_v[1] = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", longint'(obs_busy), 64'd0);
    check("abort_done", longint'(obs_done), 64'd0);
    check("abort_result", obs_res, 64'd0);
    $display("op abort w=8 a=0x77 b=0x11 -> {cout,sum}=0x%0h", obs_res);
    prev_res = '{0, 0, 0};
    run_op(1, 32'h01, 32'h02, 1'b0, 1, 1'b0, "w8_after_abort");

    for (int i = 0; i < 8; i++)
      run_op(0, 32'(i & 1), 32'((i >> 1) & 1), 1'((i >> 2) & 1), 1, 1'b0, "w1_truth");

    for (int i = 0; i < 1000; i++)
      run_op((i % 2 == 0) ? 1 : 2, $urandom, $urandom, 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
